// File: rtl/counter_sequencer_pkg.sv
// Shared state codes for the counter run-control sequencer and the board LED decode.
package counter_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_DONE  = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 pace counter, enabled only while the sequencer runs.
// Parked at zero otherwise, so each entry into RUN waits a full DIV cycles.
module tick_prescaler #(
    parameter int DIV = 25000000
) (
    input  logic Clk,
    input  logic Clr,
    input  logic Run,
    output logic Tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!Run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = Run && (cnt_q == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/step run control for the board counter: paced Enable strobes,
// one-cycle counter clear, halt when the fed-back Count reaches Limit.
//   state | meaning
//   IDLE  | stopped, waiting for Start or Step
//   RUN   | strobing Enable once per prescaler tick
//   PAUSE | held; Step strobes once, Start resumes without clearing
//   DONE  | Count reached Limit; Start restarts from zero
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 25000000
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Step,
    input  logic [WIDTH-1:0] Limit,
    input  logic [WIDTH-1:0] Count,
    output logic             Enable,
    output logic             CntClr,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       State
);

    logic       start_prev_q, stop_prev_q, step_prev_q;
    logic       start_w, stop_w, step_w;
    logic       tick, at_limit;
    seq_state_e state_q, state_d;
    logic       enable_q, enable_d;
    logic       cntclr_q, cntclr_d;

    // Prev registers come out of reset high so a button held through reset is not an edge.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            step_prev_q  <= 1'b1;
        end else begin
            start_prev_q <= Start;
            stop_prev_q  <= Stop;
            step_prev_q  <= Step;
        end
    end

    assign stop_w  = Stop & ~stop_prev_q;
    assign start_w = Start & ~start_prev_q & ~stop_w;
    assign step_w  = Step & ~step_prev_q & ~stop_w & ~(Start & ~start_prev_q);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .Clk  (Clk),
        .Clr  (Clr),
        .Run  (state_q == S_RUN),
        .Tick (tick)
    );

    assign at_limit = (Count == Limit);

    always_comb begin
        state_d  = state_q;
        enable_d = 1'b0;
        cntclr_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d  = S_RUN;
                    cntclr_d = 1'b0;
                end else if (step_w) begin
                    state_d  = S_PAUSE;
                    enable_d = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_w) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (at_limit) state_d = S_DONE;
                    else          enable_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_w) begin
                    state_d = S_IDLE;
                end else if (start_w) begin
                    state_d = S_RUN;
                end else if (step_w) begin
                    if (at_limit) state_d = S_DONE;
                    else          enable_d = 1'b1;
                end
            end
            S_DONE: begin
                if (stop_w) begin
                    state_d = S_IDLE;
                end else if (start_w) begin
                    state_d  = S_RUN;
                    cntclr_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            cntclr_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            cntclr_q <= cntclr_d;
        end
    end

    assign Enable = enable_q;
    assign CntClr = cntclr_q;
    assign Busy   = (state_q == S_RUN);
    assign Done   = (state_q == S_DONE);
    assign State  = state_q;

endmodule
